// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a_in - b_in, LSB first, valid/ready in and out; SUB_SAT_EN selects unsigned saturation
module serial_subtractor #(
  parameter int WIDTH = 8
) (
`ifdef USE_POWER_PINS
  inout  wire              vdd,
  inout  wire              vss,
`endif
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Only WIDTH-1 result bits need storage: the final bit goes straight into diff.
  logic [WIDTH-2:0] r_res;
  logic             r_bw;
  logic [CW-1:0]    r_cnt;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_d;
  logic             w_bw_next;
  logic             w_last;
  logic [WIDTH-1:0] w_cat;
  logic [WIDTH-1:0] w_diff_load;

  // One full-subtractor cell working on the current LSB of each operand.
  always_comb begin
    w_a_bit   = r_a[0];
    w_b_bit   = r_b[0];
    w_d       = w_a_bit ^ w_b_bit ^ r_bw;
    w_bw_next = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_bw);
    w_last    = (r_cnt == CW'(WIDTH - 1));
    w_cat     = {w_d, r_res};
  end

`ifdef SUB_SAT_EN
  // Clamp to zero on underflow; borrow still reports the underflow.
  assign w_diff_load = w_bw_next ? '0 : w_cat;
`else
  // Plain modulo-2^WIDTH result.
  assign w_diff_load = w_cat;
`endif

  // Control FSM with datapath shift registers and registered handshake outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_bw      <= 1'b0;
      r_cnt     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_cat[WIDTH-1:1];
          r_bw  <= w_bw_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            diff      <= w_diff_load;
            borrow    <= w_bw_next;
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         borrow;

  typedef struct {
    logic [W-1:0] d;
    logic         bw;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ready_mode = 0;  // 0: held high, 1: random, 2: held low
  logic prev_ov  = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
`ifdef USE_POWER_PINS
    .vdd       (),
    .vss       (),
`endif
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (in_a),
    .b_in      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t e;
    int   r;
    r     = int'(a) - int'(b);
    e.bw  = (r < 0);
    e.d   = W'(r < 0 ? r + 256 : r);
`ifdef SUB_SAT_EN
    if (e.bw) e.d = '0;
`endif
    e.acc = acc;
    return e;
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_result", 32'(out_valid), 32'd0);
          end else begin
            if (!prev_ov) chk("latency", 32'(cyc - q[0].acc), 32'(W));
            chk("diff", 32'(diff), 32'(q[0].d));
            chk("borrow", 32'(borrow), 32'(q[0].bw));
            chk("in_ready_low_done", 32'(in_ready), 32'd0);
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    bit got;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    got      = 1'b0;
    acc      = -1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      q.push_back(model(a, b, cyc + 1));
      @(posedge clk);
      #1;
      acc = cyc;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int prev_acc;
    int rel_cyc;
    logic [W-1:0] corners [6];
    corners[0] = 8'h00; corners[1] = 8'h01; corners[2] = 8'h7F;
    corners[3] = 8'h80; corners[4] = 8'hFE; corners[5] = 8'hFF;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    do_op(8'h5A, 8'h21, acc); in_valid = 1'b0; drain();
    do_op(8'h00, 8'h01, acc); in_valid = 1'b0; drain();
    do_op(8'h80, 8'h80, acc); in_valid = 1'b0; drain();

    // Ignored input while BUSY
    do_op(8'hC3, 8'h3C, acc);
    for (int k = 0; k < 5; k++) begin
      in_a     = W'($urandom);
      in_b     = W'($urandom);
      in_valid = ~k[0];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: hold out_ready low for 5 cycles after out_valid
    ready_mode = 2;
    do_op(8'h37, 8'h9E, acc);
    in_valid = 1'b0;
    for (int k = 0; k < 50 && !out_valid; k++) @(negedge clk);
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    ready_mode = 0;
    drain();

    // Reset in the middle of an operation
    do_op(8'hF0, 8'h0F, acc);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rel_cyc = cyc;
    do_op(8'h10, 8'h01, acc);
    in_valid = 1'b0;
    chk("first_accept_after_rst", 32'(acc), 32'(rel_cyc + 1));
    drain();

    // Corner pairs with random backpressure
    ready_mode = 1;
    foreach (corners[i]) foreach (corners[j]) begin
      do_op(corners[i], corners[j], acc);
      in_valid = 1'b0;
    end
    drain();

    // Random operands, random gaps, random backpressure
    for (int n = 0; n < 2000; n++) begin
      do_op(W'($urandom), W'($urandom), acc);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    ready_mode = 0;
    drain();

    // Back-to-back with out_ready high: fixed initiation interval
    prev_acc = -1;
    for (int n = 0; n < 300; n++) begin
      do_op(W'($urandom), W'($urandom), acc);
      if (prev_acc >= 0) chk("interval", 32'(acc - prev_acc), 32'(W + 2));
      prev_acc = acc;
    end
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
